mem_prio_arbiter: RTL and testbench



---
 rtl/mem_prio_arbiter_pkg.sv | 20 ++
 rtl/mem_prio_arbiter_src_tracker.sv | 59 +++++
 rtl/mem_prio_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_prio_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_prio_arbiter_pkg.sv
// Shared types for the memory port arbiter: request/response payloads and the grant-lock states.
package mem_prio_arbiter_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } mreq_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mtrans_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_prio_arbiter_src_tracker.sv
// In-order FIFO of requester indices for accepted, unanswered memory requests.
module mem_prio_arbiter_src_tracker #(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

  always_comb begin
    rd_d    = do_pop  ? wrap_inc(rd_q) : rd_q;
    wr_d    = do_push ? wrap_inc(wr_q) : wr_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/mem_prio_arbiter.sv
// Fixed-priority arbiter for the shared CPU memory port with starvation aging,
// a grant lock while a request is stalled, and in-order response routing.
module mem_prio_arbiter
  import mem_prio_arbiter_pkg::*;
#(
  parameter int CNT          = 2,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CNT-1:0]             master_req_valid_i,
  input  mreq_t                      master_req_data_i [CNT],
  output logic [CNT-1:0]             master_req_ready_o,
  output logic [CNT-1:0]             master_resp_valid_o,
  output mtrans_t                    master_resp_data_o [CNT],
  input  logic [CNT-1:0]             master_resp_ready_i,
  output logic                       slave_req_valid_o,
  output mreq_t                      slave_req_data_o,
  input  logic                       slave_req_ready_i,
  input  logic                       slave_resp_valid_i,
  input  mtrans_t                    slave_resp_data_i,
  output logic                       slave_resp_ready_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int IW = (CNT > 1) ? $clog2(CNT) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  arb_state_t     state_q, state_d;
  logic [IW-1:0]  lock_q, lock_d, g, head;
  logic [SW-1:0]  cnt_q [CNT];
  logic [SW-1:0]  cnt_d [CNT];
  logic [CNT-1:0] starved_q, starved_d;
  logic           any_starved, can_issue, req_fire, resp_fire, full, empty;

  always_comb begin
    g           = '0;
    any_starved = 1'b0;
    if (state_q == LOCKED) begin
      g = lock_q;
    end else begin
      for (int i = CNT - 1; i >= 1; i--) begin
        if (starved_q[i] && master_req_valid_i[i]) begin
          g           = IW'(i);
          any_starved = 1'b1;
        end
      end
      if (!any_starved) begin
        for (int i = CNT - 1; i >= 0; i--) begin
          if (master_req_valid_i[i]) g = IW'(i);
        end
      end
    end
  end

  // Gating with rst_n keeps the request side quiet for the whole reset window.
  assign slave_resp_ready_o = !empty && master_resp_ready_i[head];
  assign resp_fire          = slave_resp_valid_i && slave_resp_ready_o;
  assign can_issue          = rst_n && (!full || resp_fire);
  assign slave_req_valid_o  = master_req_valid_i[g] && can_issue;
  assign slave_req_data_o   = master_req_data_i[g];
  assign req_fire           = slave_req_valid_o && slave_req_ready_i;

  always_comb begin
    master_req_ready_o        = '0;
    master_resp_valid_o       = '0;
    master_req_ready_o[g]     = slave_req_ready_i && can_issue;
    master_resp_valid_o[head] = slave_resp_valid_i && !empty;
    for (int i = 0; i < CNT; i++) master_resp_data_o[i] = slave_resp_data_i;
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    unique case (state_q)
      IDLE: begin
        if (slave_req_valid_o && !slave_req_ready_i) begin
          state_d = LOCKED;
          lock_d  = g;
        end
      end
      LOCKED: begin
        if (req_fire) state_d = IDLE;
      end
    endcase
  end

  // Starved flag is registered one cycle behind the saturated counter.
  always_comb begin
    for (int i = 0; i < CNT; i++) begin
      cnt_d[i]     = '0;
      starved_d[i] = 1'b0;
      if (i > 0 && master_req_valid_i[i] && !(req_fire && g == IW'(i))) begin
        cnt_d[i]     = (cnt_q[i] == LIMIT) ? cnt_q[i] : cnt_q[i] + SW'(1);
        starved_d[i] = (cnt_q[i] == LIMIT);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lock_q    <= '0;
      starved_q <= '0;
      for (int i = 0; i < CNT; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      starved_q <= starved_d;
      for (int i = 0; i < CNT; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  mem_prio_arbiter_src_tracker #(
    .W     (IW),
    .DEPTH (DEPTH)
  ) u_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (req_fire),
    .data_i  (g),
    .pop_i   (resp_fire),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head),
    .count_o (count_o)
  );

endmodule

// File: tb/tb_mem_prio_arbiter.sv
// Self-checking bench for mem_prio_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_mem_prio_arbiter;
  import mem_prio_arbiter_pkg::*;

  localparam int CNT   = 2;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mreq_valid, mreq_ready, mresp_valid, mresp_ready;
  mreq_t      mreq_data [CNT];
  mtrans_t    mresp_data [CNT];
  logic       sreq_valid, sreq_ready, sresp_valid, sresp_ready;
  mreq_t      sreq_data;
  mtrans_t    sresp_data;
  logic [1:0] count;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  mem_prio_arbiter #(.CNT(CNT), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .master_req_valid_i  (mreq_valid),
    .master_req_data_i   (mreq_data),
    .master_req_ready_o  (mreq_ready),
    .master_resp_valid_o (mresp_valid),
    .master_resp_data_o  (mresp_data),
    .master_resp_ready_i (mresp_ready),
    .slave_req_valid_o   (sreq_valid),
    .slave_req_data_o    (sreq_data),
    .slave_req_ready_i   (sreq_ready),
    .slave_resp_valid_i  (sresp_valid),
    .slave_resp_data_i   (sresp_data),
    .slave_resp_ready_o  (sresp_ready),
    .count_o             (count)
  );

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    mreq_valid  = 2'b00;
    sreq_ready  = 1'b0;
    sresp_valid = 1'b0;
    mresp_ready = 2'b11;
  endtask

  function automatic mreq_t mk_req(input logic [31:0] a);
    mk_req = '{addr: a, wdata: ~a, we: a[0]};
  endfunction

  task automatic test_reset();
    rst_n         = 1'b0;
    mreq_valid    = 2'b11;
    mreq_data[0]  = mk_req(32'h10);
    mreq_data[1]  = mk_req(32'h20);
    sreq_ready    = 1'b1;
    sresp_valid   = 1'b1;
    sresp_data    = '{rdata: 32'h55, err: 1'b0};
    mresp_ready   = 2'b11;
    #3;
    tests++; if (sreq_valid !== 1'b0) begin fails++; $display("FAIL reset_sreq_valid got %b want 0", sreq_valid); end
    tests++; if (mreq_ready !== 2'b00) begin fails++; $display("FAIL reset_mreq_ready got %b want 00", mreq_ready); end
    tests++; if (mresp_valid !== 2'b00) begin fails++; $display("FAIL reset_mresp_valid got %b want 00", mresp_valid); end
    tests++; if (sresp_ready !== 1'b0) begin fails++; $display("FAIL reset_sresp_ready got %b want 0", sresp_ready); end
    tests++; if (count !== 2'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    idle_inputs();
    next();
    rst_n = 1'b1;
    next();
  endtask

  task automatic test_single();
    sreq_ready  = 1'b1;
    mresp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      mreq_valid   = (k < 3) ? 2'b10 : 2'b00;
      mreq_data[1] = mk_req(32'h100 + k);
      sresp_valid  = (k > 0);
      sresp_data   = '{rdata: 32'hA00 + k, err: 1'b0};
      #1;
      if (k < 3) begin
        tests++; if (mreq_ready !== 2'b10) begin fails++; $display("FAIL single_ready[%0d] got %b want 10", k, mreq_ready); end
        tests++; if (sreq_data.addr !== 32'h100 + k) begin fails++; $display("FAIL single_addr[%0d] got %h want %h", k, sreq_data.addr, 32'h100 + k); end
      end
      if (k > 0) begin
        tests++; if (mresp_valid !== 2'b10) begin fails++; $display("FAIL single_resp_valid[%0d] got %b want 10", k, mresp_valid); end
        tests++; if (mresp_data[1].rdata !== 32'hA00 + k) begin fails++; $display("FAIL single_resp_data[%0d] got %h want %h", k, mresp_data[1].rdata, 32'hA00 + k); end
      end
      next();
    end
    idle_inputs();
    tests++; if (count !== 2'd0) begin fails++; $display("FAIL single_count got %0d want 0", count); end
  endtask

  task automatic test_priority();
    sreq_ready   = 1'b1;
    mreq_valid   = 2'b11;
    mreq_data[0] = mk_req(32'h200);
    mreq_data[1] = mk_req(32'h300);
    #1;
    tests++; if (mreq_ready !== 2'b01 || sreq_data.addr !== 32'h200) begin fails++; $display("FAIL prio_first got ready=%b addr=%h want 01/200", mreq_ready, sreq_data.addr); end
    next();
    mreq_valid = 2'b10;
    #1;
    tests++; if (mreq_ready !== 2'b10 || sreq_data.addr !== 32'h300) begin fails++; $display("FAIL prio_second got ready=%b addr=%h want 10/300", mreq_ready, sreq_data.addr); end
    next();
    idle_inputs();
    sresp_valid = 1'b1;
    #1;
    tests++; if (mresp_valid !== 2'b01) begin fails++; $display("FAIL prio_resp0 got %b want 01", mresp_valid); end
    next();
    tests++; if (mresp_valid !== 2'b10) begin fails++; $display("FAIL prio_resp1 got %b want 10", mresp_valid); end
    next();
    sresp_valid = 1'b0;
  endtask

  task automatic test_lock();
    mreq_data[0] = mk_req(32'h400);
    mreq_data[1] = mk_req(32'h500);
    for (int c = 0; c < 5; c++) begin
      mreq_valid = (c == 0) ? 2'b10 : (c == 4) ? 2'b01 : 2'b11;
      sreq_ready = (c >= 3);
      #1;
      if (c < 4) begin
        tests++; if (sreq_valid !== 1'b1 || sreq_data.addr !== 32'h500) begin fails++; $display("FAIL lock_hold[%0d] got valid=%b addr=%h want 1/500", c, sreq_valid, sreq_data.addr); end
      end
      tests++;
      if (mreq_ready !== ((c < 3) ? 2'b00 : (c == 3) ? 2'b10 : 2'b01)) begin
        fails++; $display("FAIL lock_ready[%0d] got %b", c, mreq_ready);
      end
      next();
    end
    idle_inputs();
    sresp_valid = 1'b1;
    #1;
    tests++; if (mresp_valid !== 2'b10) begin fails++; $display("FAIL lock_resp_order0 got %b want 10", mresp_valid); end
    next();
    tests++; if (mresp_valid !== 2'b01) begin fails++; $display("FAIL lock_resp_order1 got %b want 01", mresp_valid); end
    next();
    sresp_valid = 1'b0;
  endtask

  task automatic test_starvation();
    sreq_ready   = 1'b1;
    sresp_valid  = 1'b1;
    mresp_ready  = 2'b11;
    mreq_data[1] = mk_req(32'h600);
    for (int c = 0; c < 8; c++) begin
      mreq_valid   = 2'b11;
      mreq_data[0] = mk_req(32'h700 + c);
      #1;
      tests++;
      if (mreq_ready !== ((c == 5) ? 2'b10 : 2'b01)) begin
        fails++; $display("FAIL starve_grant[%0d] got %b want %b", c, mreq_ready, (c == 5) ? 2'b10 : 2'b01);
      end
      if (c == 0) begin
        tests++; if (sresp_ready !== 1'b0) begin fails++; $display("FAIL starve_empty_resp got %b want 0", sresp_ready); end
      end
      next();
    end
    mreq_valid = 2'b00;
    next();
    idle_inputs();
    tests++; if (count !== 2'd0) begin fails++; $display("FAIL starve_drain got %0d want 0", count); end
  endtask

  task automatic test_full();
    sreq_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      mreq_valid             = (c == 0) ? 2'b01 : 2'b10;
      mreq_data[c]           = mk_req(32'h800 + c);
      next();
    end
    mreq_valid   = 2'b01;
    mreq_data[0] = mk_req(32'h802);
    #1;
    tests++; if (mreq_ready !== 2'b00 || sreq_valid !== 1'b0) begin fails++; $display("FAIL full_stall got ready=%b valid=%b want 00/0", mreq_ready, sreq_valid); end
    tests++; if (count !== 2'd2) begin fails++; $display("FAIL full_count got %0d want 2", count); end
    next();
    sresp_valid = 1'b1;
    sresp_data  = '{rdata: 32'hAA, err: 1'b0};
    #1;
    tests++; if (mreq_ready !== 2'b01 || sreq_valid !== 1'b1) begin fails++; $display("FAIL full_pushpop got ready=%b valid=%b want 01/1", mreq_ready, sreq_valid); end
    tests++; if (mresp_valid !== 2'b01) begin fails++; $display("FAIL full_resp0 got %b want 01", mresp_valid); end
    next();
    mreq_valid = 2'b00;
    sresp_data = '{rdata: 32'hBB, err: 1'b1};
    #1;
    tests++; if (count !== 2'd2) begin fails++; $display("FAIL full_count_hold got %0d want 2", count); end
    tests++; if (mresp_valid !== 2'b10 || mresp_data[1] !== sresp_data) begin fails++; $display("FAIL full_resp1 got %b/%h want 10/%h", mresp_valid, mresp_data[1], sresp_data); end
    mresp_ready = 2'b10;
    sresp_data  = '{rdata: 32'hBB, err: 1'b1};
    next();
    mresp_ready = 2'b10;
    #1;
    tests++; if (mresp_valid !== 2'b01 || sresp_ready !== 1'b0) begin fails++; $display("FAIL full_head_notready got %b/%b want 01/0", mresp_valid, sresp_ready); end
    mresp_ready = 2'b11;
    next();
    idle_inputs();
    tests++; if (count !== 2'd0) begin fails++; $display("FAIL full_drain got %0d want 0", count); end
  endtask

  task automatic test_reset_mid();
    sreq_ready   = 1'b1;
    mreq_data[0] = mk_req(32'h900);
    mreq_data[1] = mk_req(32'h901);
    mreq_valid   = 2'b01; next();
    mreq_valid   = 2'b10; next();
    mreq_data[0] = mk_req(32'h902);
    mreq_valid   = 2'b01;
    sreq_ready   = 1'b0;
    sresp_valid  = 1'b1;
    next();
    sresp_valid  = 1'b0;
    mreq_valid   = 2'b11;
    #1;
    tests++; if (count !== 2'd1 || sreq_data.addr !== 32'h902) begin fails++; $display("FAIL rmid_setup got count=%0d addr=%h want 1/902", count, sreq_data.addr); end
    rst_n       = 1'b0;
    sreq_ready  = 1'b1;
    sresp_valid = 1'b1;
    #1;
    tests++; if (sreq_valid !== 1'b0 || mreq_ready !== 2'b00) begin fails++; $display("FAIL rmid_req got valid=%b ready=%b want 0/00", sreq_valid, mreq_ready); end
    tests++; if (mresp_valid !== 2'b00 || sresp_ready !== 1'b0) begin fails++; $display("FAIL rmid_resp got valid=%b ready=%b want 00/0", mresp_valid, sresp_ready); end
    tests++; if (count !== 2'd0) begin fails++; $display("FAIL rmid_count got %0d want 0", count); end
    next();
    rst_n       = 1'b1;
    sresp_valid = 1'b0;
    mreq_valid  = 2'b10;
    #1;
    tests++; if (mreq_ready !== 2'b10 || sreq_valid !== 1'b1) begin fails++; $display("FAIL rmid_after got ready=%b valid=%b want 10/1", mreq_ready, sreq_valid); end
    next();
    idle_inputs();
    sresp_valid = 1'b1;
    next();
    sresp_valid = 1'b0;
    #1;
    tests++; if (count !== 2'd0) begin fails++; $display("FAIL rmid_drain got %0d want 0", count); end
  endtask

  task automatic test_random(input int n);
    int         held, g, head;
    int         waits [2];
    int         q [$];
    logic [1:0] fired, er, evr;
    logic       resp_ok, room, ev, fire;
    int         errs;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    next();
    held  = -1;
    waits = '{0, 0};
    q.delete();
    fired = 2'b11;
    errs  = 0;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (fired[i] || !mreq_valid[i]) begin
          mreq_valid[i] = ($urandom_range(0, 99) < ((i == 0) ? 70 : 50));
          mreq_data[i]  = mk_req($urandom);
        end
      end
      sreq_ready  = ($urandom_range(0, 3) != 0);
      sresp_valid = 1'($urandom_range(0, 1));
      sresp_data  = '{rdata: $urandom, err: 1'($urandom_range(0, 1))};
      mresp_ready = 2'($urandom);
      #1;
      head    = (q.size() > 0) ? q[0] : 0;
      resp_ok = sresp_valid && q.size() > 0 && mresp_ready[head];
      room    = (q.size() < DEPTH) || resp_ok;
      if (held >= 0) g = held;
      else if (mreq_valid[1] && waits[1] > LIMIT) g = 1;
      else if (mreq_valid[0]) g = 0;
      else if (mreq_valid[1]) g = 1;
      else g = 0;
      ev    = mreq_valid[g] && room;
      er    = 2'b00;
      er[g] = sreq_ready && room;
      evr   = 2'b00;
      if (sresp_valid && q.size() > 0) evr[head] = 1'b1;
      tests++; if (sreq_valid !== ev) begin fails++; errs++; if (errs < 10) $display("FAIL rnd_sreq_valid c=%0d got %b want %b", c, sreq_valid, ev); end
      tests++; if (mreq_ready !== er) begin fails++; errs++; if (errs < 10) $display("FAIL rnd_mreq_ready c=%0d got %b want %b", c, mreq_ready, er); end
      if (ev) begin
        tests++; if (sreq_data !== mreq_data[g]) begin fails++; errs++; if (errs < 10) $display("FAIL rnd_sreq_data c=%0d got %h want %h", c, sreq_data, mreq_data[g]); end
      end
      tests++; if (sresp_ready !== (q.size() > 0 && mresp_ready[head])) begin fails++; errs++; if (errs < 10) $display("FAIL rnd_sresp_ready c=%0d got %b", c, sresp_ready); end
      tests++; if (mresp_valid !== evr) begin fails++; errs++; if (errs < 10) $display("FAIL rnd_mresp_valid c=%0d got %b want %b", c, mresp_valid, evr); end
      if (evr != 2'b00) begin
        tests++; if (mresp_data[head] !== sresp_data) begin fails++; errs++; if (errs < 10) $display("FAIL rnd_mresp_data c=%0d got %h want %h", c, mresp_data[head], sresp_data); end
      end
      tests++; if (count !== 2'(q.size())) begin fails++; errs++; if (errs < 10) $display("FAIL rnd_count c=%0d got %0d want %0d", c, count, q.size()); end
      fire  = ev && sreq_ready;
      fired = 2'b00;
      if (fire) fired[g] = 1'b1;
      if (resp_ok) void'(q.pop_front());
      if (fire) q.push_back(g);
      held = fire ? -1 : ((ev && !sreq_ready) ? g : held);
      for (int i = 0; i < 2; i++) waits[i] = (mreq_valid[i] && !fired[i]) ? waits[i] + 1 : 0;
      next();
    end
    idle_inputs();
  endtask

  initial begin
    mreq_data[0] = '0;
    mreq_data[1] = '0;
    sresp_data   = '0;
    test_reset();
    test_single();
    test_priority();
    test_lock();
    test_starvation();
    test_full();
    test_reset_mid();
    test_random(3000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
